store_commit_queue: RTL and testbench
=====================================

Name: store_commit_queue

Overview:
- Buffers stores from the LSU in program order and holds them speculative until the commit stage pulses fire_store, which marks the oldest uncommitted entry as committed.
- Committed entries drain to the data-memory port, oldest first, through a req/ack handshake. Flush discards the uncommitted tail and keeps the committed entries.
- Sits between the LSU store path, the commit stage (fire_store, flush) and the D-side memory interface. It also provides combinational store-to-load forwarding.

Parameters:
DEPTH, 8, number of entries (power of 2, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, store data width (wstrb width = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  discard all uncommitted entries
enq_valid  in  1  LSU store enqueue request
enq_ready  out  1  queue can accept a store
enq_addr  in  ADDR_W  store byte address
enq_data  in  DATA_W  store data, pre-aligned to word lanes
enq_wstrb  in  DATA_W/8  byte enables
fire_store  in  1  commit the oldest uncommitted store
mem_req  out  1  write request to memory
mem_addr  out  ADDR_W  address of head entry
mem_wdata  out  DATA_W  data of head entry
mem_wstrb  out  DATA_W/8  byte enables of head entry
mem_ack  in  1  memory accepted the write
ld_addr  in  ADDR_W  load address for the forwarding lookup
ld_fwd_data  out  DATA_W  merged forwarded bytes
ld_fwd_strb  out  DATA_W/8  bytes supplied by the queue
count  out  $clog2(DEPTH)+1  valid entries
commit_err  out  1  sticky: fire_store seen with no uncommitted entry

Behaviour:
- Storage: circular buffer with three pointers, each log2(DEPTH) bits plus a wrap bit.
  - head: oldest entry.
  - cptr: oldest uncommitted entry.
  - tail: next free slot.
  - Invariant: head <= cptr <= tail (modular). Full when tail-head == DEPTH; empty when tail == head.
- Reset: all pointers 0, state IDLE, mem_req=0, commit_err=0, count=0, enq_ready=1. Reset mid-handshake drops the request and all entries.
- Enqueue:
  - enq_ready = !full && !flush.
  - When enq_valid && enq_ready at an edge, write addr/data/wstrb at tail and advance tail.
  - No bypass: a simultaneous pop does not allow enqueue at full.
- Commit:
  - fire_store at an edge advances cptr by 1 when cptr != tail.
  - If cptr == tail, the pulse is ignored and commit_err is set; it stays set until rst.
- Flush:
  - At the edge, tail := cptr after any same-cycle fire_store has been applied, so the committing store survives.
  - A same-cycle enq is dropped.
  - Committed entries and any in-flight mem_req are unaffected.
- Drain FSM:
  - IDLE: mem_req=0. When committed count (cptr-head) > 0, go to REQ at the next edge.
  - REQ: mem_req=1. mem_addr/wdata/wstrb come from the head entry and stay stable until ack.
  - On mem_req && mem_ack at an edge, head advances.
  - After an ack: if (cptr_next - head_next) > 0, including a same-cycle fire_store, stay in REQ and present the next head. Otherwise go to IDLE.
  - Minimum latency: fire_store at edge E, mem_req high after edge E+1. Back-to-back acks give one write per cycle.
- Forwarding (combinational, all valid entries, committed or not):
  - Compare entry addr[ADDR_W-1:2] with ld_addr[ADDR_W-1:2].
  - Per byte lane, take the youngest matching entry whose wstrb bit is set. ld_fwd_strb marks the covered lanes; uncovered lanes of ld_fwd_data are 0.
  - Entries are searched tail-1 back to head with correct wrap handling.
- count = tail-head, registered-pointer based. Wrap-around at DEPTH is transparent: pointer compare uses the wrap bit.

Test Plan:
- Reset, enq 3 stores (0x100/0xAABBCCDD/4'hF, 0x104, 0x108), 3 fire_store pulses, mem_ack held high -> mem_req rises 2 cycles after the first pulse; 3 writes go out in order, one per cycle; count returns to 0.
- Enq 2 stores, fire_store once, then flush -> the first store drains to 0x100; the second is discarded; count=0 after the ack; commit_err=0.
- Fill to DEPTH=8 -> enq_ready=0. Commit all, ack with 2-cycle gaps -> mem_addr stable while unacked. Keep enqueuing across the wrap -> order preserved across the pointer wrap.
- Enq 0x200/0x11223344/4'b0011, then 0x200/0x55667788/4'b0110; ld_addr=0x202 -> ld_fwd_strb=4'b0111, ld_fwd_data=0x00667744.
- fire_store on an empty queue -> commit_err=1 and sticky, no pointer change. rst -> commit_err=0.
- Same cycle: fire_store + flush + enq_valid with 1 uncommitted entry -> that entry becomes committed and drains; the enq is dropped; enq_ready=0 in that cycle.

Source files
------------

// File: rtl/store_commit_queue.sv
// Store commit queue: program-ordered store buffer with commit, flush,
// in-order drain to data memory and store-to-load forwarding.
module store_commit_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [ADDR_W-1:0]       enq_addr,
    input  logic [DATA_W-1:0]       enq_data,
    input  logic [DATA_W/8-1:0]     enq_wstrb,
    input  logic                    fire_store,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_wstrb,
    input  logic                    mem_ack,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic [DATA_W-1:0]       ld_fwd_data,
    output logic [DATA_W/8-1:0]     ld_fwd_strb,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    commit_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DATA_W / 8;

    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_next;

    logic [CW-1:0] head, cptr, tail;
    logic [CW-1:0] head_next, cptr_next, tail_next;
    logic          full, do_enq, do_commit, do_pop;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [SW-1:0]     wstrb_q [DEPTH];

    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    assign count     = tail - head;
    assign full      = (count == CW'(DEPTH));
    assign enq_ready = !full && !flush;
    assign do_enq    = enq_valid && enq_ready;
    assign do_commit = fire_store && (cptr != tail);
    assign do_pop    = mem_req && mem_ack;

    // Flush truncates to the post-commit cptr so a same-cycle commit survives.
    always_comb begin
        head_next = head + CW'(do_pop);
        cptr_next = cptr + CW'(do_commit);
        tail_next = flush ? cptr_next : tail + CW'(do_enq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            cptr       <= '0;
            tail       <= '0;
            commit_err <= 1'b0;
        end else begin
            head <= head_next;
            cptr <= cptr_next;
            tail <= tail_next;
            if (fire_store && (cptr == tail))
                commit_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_q[tail[PW-1:0]]  <= enq_addr;
            data_q[tail[PW-1:0]]  <= enq_data;
            wstrb_q[tail[PW-1:0]] <= enq_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cptr != head) state_next = REQ;
            REQ:  if (do_pop && (cptr_next == head_next)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        if (state == REQ)
            mem_req = 1'b1;
    end

    assign mem_addr  = addr_q[head[PW-1:0]];
    assign mem_wdata = data_q[head[PW-1:0]];
    assign mem_wstrb = wstrb_q[head[PW-1:0]];

    // Walk oldest to youngest so younger matches overwrite older lanes.
    always_comb begin
        logic [PW-1:0] slot;
        ld_fwd_data = '0;
        ld_fwd_strb = '0;
        slot        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head[PW-1:0] + PW'(i);
            if ((CW'(i) < count) && (addr_q[slot][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                for (int unsigned b = 0; b < SW; b++) begin
                    if (wstrb_q[slot][b]) begin
                        ld_fwd_data[b*8 +: 8] = data_q[slot][b*8 +: 8];
                        ld_fwd_strb[b]        = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_store_commit_queue.sv
// Self-checking bench for store_commit_queue: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_store_commit_queue;
    logic        clk = 1'b0;
    logic        rst, flush, enq_valid, fire_store, mem_ack;
    logic [31:0] enq_addr, enq_data, ld_addr;
    logic [3:0]  enq_wstrb;
    logic        enq_ready, mem_req, commit_err;
    logic [31:0] mem_addr, mem_wdata, ld_fwd_data;
    logic [3:0]  mem_wstrb, ld_fwd_strb;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t q[$];
    int   ncom;
    bit   merr, mreq;

    store_commit_queue #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data), .enq_wstrb(enq_wstrb),
        .fire_store(fire_store),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_fwd_data(ld_fwd_data), .ld_fwd_strb(ld_fwd_strb),
        .count(count), .commit_err(commit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic ev, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic fs, input logic fl, input logic ack);
        enq_valid  = ev;
        enq_addr   = a;
        enq_data   = d;
        enq_wstrb  = s;
        fire_store = fs;
        flush      = fl;
        mem_ack    = ack;
    endtask

    task automatic check_model();
        logic [31:0] fd;
        logic [3:0]  fs;
        chk("count", 32'(count), q.size());
        chk("enq_ready", 32'(enq_ready), 32'((q.size() < 8) && !flush));
        chk("mem_req", 32'(mem_req), 32'(mreq));
        chk("commit_err", 32'(commit_err), 32'(merr));
        if (mreq) begin
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_wdata", mem_wdata, q[0].d);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].s));
        end
        fd = '0;
        fs = '0;
        for (int b = 0; b < 4; b++) begin
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].a[31:2] == ld_addr[31:2] && q[k].s[b]) begin
                    fd[b*8 +: 8] = q[k].d[b*8 +: 8];
                    fs[b]        = 1'b1;
                    break;
                end
            end
        end
        chk("fwd_strb", 32'(ld_fwd_strb), 32'(fs));
        chk("fwd_data", ld_fwd_data, fd);
    endtask

    task automatic model_step();
        int size_pre, nc;
        bit pop, rdy;
        ent_t e;
        size_pre = q.size();
        nc       = ncom;
        pop      = mreq && mem_ack;
        rdy      = (size_pre < 8) && !flush;
        if (pop) begin
            q.delete(0);
            nc--;
        end
        if (fire_store) begin
            if (ncom < size_pre) nc++;
            else merr = 1'b1;
        end
        if (flush)
            while (q.size() > nc) q.delete(q.size() - 1);
        if (enq_valid && rdy) begin
            e.a = enq_addr;
            e.d = enq_data;
            e.s = enq_wstrb;
            q.push_back(e);
        end
        mreq = mreq ? (pop ? (nc > 0) : 1'b1) : (ncom > 0);
        ncom = nc;
    endtask

    // Inputs are already driven at posedge+1; check, advance model, cross edge.
    task automatic cyc();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        set_in(0, '0, '0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        q.delete();
        ncom = 0;
        merr = 1'b0;
        mreq = 1'b0;
    endtask

    initial begin
        ld_addr = 32'h0;
        reset_dut();
        chk("rst_count", 32'(count), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_commit_err", 32'(commit_err), 0);

        // Three stores, three commits, ack held high.
        ld_addr = 32'h100;
        set_in(1, 32'h100, 32'hAABBCCDD, 4'hF, 0, 0, 1); cyc();
        set_in(1, 32'h104, 32'h01020304, 4'hF, 0, 0, 1); cyc();
        set_in(1, 32'h108, 32'h05060708, 4'hF, 0, 0, 1); cyc();
        set_in(0, '0, '0, '0, 1, 0, 1); cyc();
        chk("t1_req_after_1", 32'(mem_req), 0);
        set_in(0, '0, '0, '0, 1, 0, 1); cyc();
        chk("t1_req_after_2", 32'(mem_req), 1);
        chk("t1_addr0", mem_addr, 32'h100);
        chk("t1_data0", mem_wdata, 32'hAABBCCDD);
        set_in(0, '0, '0, '0, 1, 0, 1); cyc();
        chk("t1_addr1", mem_addr, 32'h104);
        set_in(0, '0, '0, '0, 0, 0, 1); cyc();
        chk("t1_addr2", mem_addr, 32'h108);
        cyc();
        chk("t1_count0", 32'(count), 0);
        chk("t1_idle", 32'(mem_req), 0);

        // Commit one of two, then flush.
        set_in(1, 32'h100, 32'h11111111, 4'hF, 0, 0, 0); cyc();
        set_in(1, 32'h104, 32'h22222222, 4'hF, 0, 0, 0); cyc();
        set_in(0, '0, '0, '0, 1, 0, 0); cyc();
        set_in(0, '0, '0, '0, 0, 1, 0); cyc();
        chk("t2_count1", 32'(count), 1);
        chk("t2_req", 32'(mem_req), 1);
        chk("t2_addr", mem_addr, 32'h100);
        set_in(0, '0, '0, '0, 0, 0, 1); cyc();
        chk("t2_count0", 32'(count), 0);
        chk("t2_err", 32'(commit_err), 0);

        // Fill, then commit and drain with ack gaps while enqueuing across the wrap.
        for (int i = 0; i < 8; i++) begin
            set_in(1, 32'h400 + 32'(i * 4), $urandom, 4'hF, 0, 0, 0); cyc();
        end
        chk("t3_full_ready", 32'(enq_ready), 0);
        chk("t3_full_count", 32'(count), 8);
        begin
            int added = 0;
            for (int c = 0; c < 60; c++) begin
                set_in(added < 10, 32'h500 + 32'(added * 4), $urandom, 4'($urandom),
                       ncom < q.size(), 0, (c % 3) == 2);
                if (enq_valid && q.size() < 8) added++;
                cyc();
            end
        end
        chk("t3_drained", 32'(count), 0);
        chk("t3_err", 32'(commit_err), 0);

        // Forwarding merge across two overlapping stores.
        reset_dut();
        ld_addr = 32'h202;
        set_in(1, 32'h200, 32'h11223344, 4'b0011, 0, 0, 0); cyc();
        set_in(1, 32'h200, 32'h55667788, 4'b0110, 0, 0, 0); cyc();
        chk("t4_fwd_strb", 32'(ld_fwd_strb), 32'h7);
        chk("t4_fwd_data", ld_fwd_data, 32'h00667744);
        set_in(0, '0, '0, '0, 0, 1, 0); cyc();
        chk("t4_flushed", 32'(count), 0);

        // Commit on empty queue sets a sticky error.
        set_in(0, '0, '0, '0, 1, 0, 0); cyc();
        chk("t5_err_set", 32'(commit_err), 1);
        chk("t5_count", 32'(count), 0);
        set_in(0, '0, '0, '0, 0, 0, 0); cyc(); cyc();
        chk("t5_err_sticky", 32'(commit_err), 1);
        reset_dut();
        chk("t5_err_clear", 32'(commit_err), 0);

        // fire_store + flush + enq in one cycle.
        set_in(1, 32'h600, 32'hCAFEF00D, 4'hF, 0, 0, 0); cyc();
        set_in(1, 32'h604, 32'hDEADBEEF, 4'hF, 1, 1, 0);
        #1;
        chk("t6_enq_ready", 32'(enq_ready), 0);
        cyc();
        chk("t6_count", 32'(count), 1);
        set_in(0, '0, '0, '0, 0, 0, 1); cyc();
        chk("t6_req", 32'(mem_req), 1);
        chk("t6_addr", mem_addr, 32'h600);
        cyc();
        chk("t6_count0", 32'(count), 0);
        chk("t6_err", 32'(commit_err), 0);

        // Random traffic over a small address window, with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_dut();
            end else begin
                ld_addr = 32'h300 + 32'($urandom_range(0, 15));
                set_in($urandom_range(0, 1) == 1,
                       32'h300 + 32'($urandom_range(0, 3) * 4), $urandom, 4'($urandom),
                       $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) < 6);
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
